// File: rtl/ram_offset_gen.sv
// Feature-index walker that streams top/side RAM offsets for one conv-layer job.
// Offsets are derived combinationally from the registered index, layer and bases.
module ram_offset_gen #(
  parameter int unsigned                    FIDX_W        = 9,
  parameter int unsigned                    LAYER_W       = 3,
  parameter int unsigned                    ADDR_W        = 13,
  parameter int unsigned                    NUM_LAYERS    = 6,
  parameter logic [4*NUM_LAYERS-1:0]        TOP_SHIFT_TBL = 24'h012344,
  parameter int unsigned                    SIDE_SHIFT    = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [LAYER_W-1:0]  layer_i,
  input  logic [FIDX_W:0]     fcount_i,
  input  logic [ADDR_W-1:0]   base_top_i,
  input  logic [ADDR_W-1:0]   base_side_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [ADDR_W-1:0]   top_offset_o,
  output logic [ADDR_W-1:0]   side_offset_o,
  output logic [FIDX_W-1:0]   feature_index_o,
  output logic                last_o,
  output logic                busy_o,
  output logic                err_o
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  localparam int unsigned EXT_W = ADDR_W + FIDX_W;

  state_t              state_q, state_d;
  logic [LAYER_W-1:0]  layer_q, layer_d;
  logic [FIDX_W:0]     fcount_q, fcount_d;
  logic [ADDR_W-1:0]   btop_q, btop_d;
  logic [ADDR_W-1:0]   bside_q, bside_d;
  logic [FIDX_W-1:0]   idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic                job_ok;
  logic                is_last;
  logic [3:0]          top_sh;
  logic [EXT_W-1:0]    idx_ext;
  logic [EXT_W-1:0]    top_prod;
  logic [EXT_W-1:0]    side_prod;

  assign job_ok  = (32'(layer_i) < NUM_LAYERS) && (fcount_i != '0);
  assign is_last = valid_q && ({1'b0, idx_q} == (fcount_q - (FIDX_W+1)'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      layer_q  <= '0;
      fcount_q <= '0;
      btop_q   <= '0;
      bside_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      fcount_q <= fcount_d;
      btop_q   <= btop_d;
      bside_q  <= bside_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    fcount_d = fcount_q;
    btop_d   = btop_q;
    bside_d  = bside_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (job_ok) begin
            layer_d  = layer_i;
            fcount_d = fcount_i;
            btop_d   = base_top_i;
            bside_d  = base_side_i;
            idx_d    = '0;
            valid_d  = 1'b1;
            state_d  = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (ready_i) begin
          if (is_last) begin
            idx_d   = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + FIDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Layer is only ever latched below NUM_LAYERS, so unmatched layers never occur in RUN.
  always_comb begin
    top_sh = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (layer_q == LAYER_W'(i)) top_sh = TOP_SHIFT_TBL[4*i +: 4];
    end
  end

  assign idx_ext   = EXT_W'(idx_q);
  assign top_prod  = idx_ext << top_sh;
  assign side_prod = idx_ext << SIDE_SHIFT;

  assign top_offset_o    = btop_q + top_prod[ADDR_W-1:0];
  assign side_offset_o   = bside_q + side_prod[ADDR_W-1:0];
  assign feature_index_o = idx_q;
  assign last_o          = is_last;
  assign valid_o         = valid_q;
  assign busy_o          = (state_q == RUN);
  assign err_o           = err_q;

endmodule

// File: tb/tb_ram_offset_gen.sv
// Self-checking bench: vector table of jobs, random jobs, and hand-written stall/reset/ignore sequences.
module tb_ram_offset_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  layer;
  logic [9:0]  fcount;
  logic [12:0] base_top;
  logic [12:0] base_side;
  logic        valid;
  logic        ready;
  logic [12:0] top_off;
  logic [12:0] side_off;
  logic [8:0]  fidx;
  logic        last;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_offset_gen #(
    .FIDX_W(9), .LAYER_W(3), .ADDR_W(13), .NUM_LAYERS(6),
    .TOP_SHIFT_TBL(24'h012344), .SIDE_SHIFT(3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .layer_i(layer), .fcount_i(fcount),
    .base_top_i(base_top), .base_side_i(base_side), .valid_o(valid), .ready_i(ready),
    .top_offset_o(top_off), .side_offset_o(side_off), .feature_index_o(fidx),
    .last_o(last), .busy_o(busy), .err_o(err)
  );

  // Top-RAM shift per layer: layers 0..5 shift by 4,4,3,2,1,0.
  int top_shift [6] = '{4, 4, 3, 2, 1, 0};

  function automatic int exp_top(int lay, int k, int bt);
    return (bt + k * (1 << top_shift[lay])) % 8192;
  endfunction

  function automatic int exp_side(int k, int bs);
    return (bs + k * 8) % 8192;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " valid"}, int'(valid), 0);
    chk({tag, " last"},  int'(last), 0);
    chk({tag, " busy"},  int'(busy), 0);
    chk({tag, " err"},   int'(err), 0);
    chk({tag, " top"},   int'(top_off), 0);
    chk({tag, " side"},  int'(side_off), 0);
    chk({tag, " idx"},   int'(fidx), 0);
  endtask

  // Runs one job end to end; rand_rdy throttles ready, noise keeps start_i busy during RUN.
  task automatic run_job(input int lay, input int fc, input int bt, input int bs,
                         input bit rand_rdy, input bit noise);
    int k;
    int budget;
    start     = 1'b1;
    layer     = 3'(lay);
    fcount    = 10'(fc);
    base_top  = 13'(bt);
    base_side = 13'(bs);
    ready     = 1'b1;
    step();
    start = 1'b0;
    if (lay >= 6 || fc == 0) begin
      chk("rej err", int'(err), 1);
      chk("rej valid", int'(valid), 0);
      chk("rej busy", int'(busy), 0);
      step();
      chk("rej err clear", int'(err), 0);
      chk("rej busy after", int'(busy), 0);
      return;
    end
    chk("job err", int'(err), 0);
    chk("job busy", int'(busy), 1);
    k = 0;
    budget = 4 * fc + 20;
    while (k < fc && budget > 0) begin
      budget--;
      ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        start     = 1'b1;
        layer     = 3'($urandom_range(0, 7));
        fcount    = 10'($urandom_range(0, 1023));
        base_top  = 13'($urandom);
        base_side = 13'($urandom);
      end
      chk("beat valid", int'(valid), 1);
      chk("beat idx", int'(fidx), k);
      chk("beat top", int'(top_off), exp_top(lay, k, bt));
      chk("beat side", int'(side_off), exp_side(k, bs));
      chk("beat last", int'(last), (k == fc - 1) ? 1 : 0);
      if (ready) k++;
      step();
    end
    start = 1'b0;
    ready = 1'b0;
    chk("job timeout", int'(budget > 0 || k == fc), 1);
    chk("end valid", int'(valid), 0);
    chk("end last", int'(last), 0);
    chk("end busy", int'(busy), 0);
  endtask

  typedef struct {
    int lay;
    int fc;
    int bt;
    int bs;
    bit rand_rdy;
    bit noise;
  } job_t;

  job_t table_v [8];

  initial begin
    table_v[0] = '{lay: 3, fc: 4,   bt: 0,    bs: 0,    rand_rdy: 0, noise: 0};
    table_v[1] = '{lay: 6, fc: 4,   bt: 0,    bs: 0,    rand_rdy: 0, noise: 0};
    table_v[2] = '{lay: 2, fc: 0,   bt: 0,    bs: 0,    rand_rdy: 0, noise: 0};
    table_v[3] = '{lay: 5, fc: 512, bt: 0,    bs: 8000, rand_rdy: 0, noise: 0};
    table_v[4] = '{lay: 0, fc: 512, bt: 17,   bs: 3,    rand_rdy: 1, noise: 0};
    table_v[5] = '{lay: 4, fc: 7,   bt: 8190, bs: 8191, rand_rdy: 1, noise: 0};
    table_v[6] = '{lay: 0, fc: 6,   bt: 1000, bs: 2000, rand_rdy: 0, noise: 1};
    table_v[7] = '{lay: 7, fc: 1,   bt: 5,    bs: 5,    rand_rdy: 0, noise: 0};

    rst = 1'b1; start = 1'b0; layer = '0; fcount = '0;
    base_top = '0; base_side = '0; ready = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    foreach (table_v[i])
      run_job(table_v[i].lay, table_v[i].fc, table_v[i].bt, table_v[i].bs,
              table_v[i].rand_rdy, table_v[i].noise);

    // Stall: ready low for three cycles after first valid.
    start = 1'b1; layer = 3'd1; fcount = 10'd2; base_top = 13'd100; base_side = 13'd5;
    ready = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall top", int'(top_off), 100);
      chk("stall side", int'(side_off), 5);
      chk("stall last", int'(last), 0);
      step();
    end
    ready = 1'b1;
    chk("stall top0", int'(top_off), 100);
    step();
    chk("stall top1", int'(top_off), 116);
    chk("stall side1", int'(side_off), 13);
    chk("stall last1", int'(last), 1);
    step();
    chk("stall done busy", int'(busy), 0);
    chk("stall done valid", int'(valid), 0);

    // Reset during beat 2 of a 10-beat job, with a start request in the reset cycle.
    start = 1'b1; layer = 3'd2; fcount = 10'd10; base_top = 13'd300; base_side = 13'd40;
    ready = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("pre-rst idx", int'(fidx), 1);
    rst = 1'b1;
    start = 1'b1; layer = 3'd1; fcount = 10'd3;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("post-rst busy", int'(busy), 0);
    run_job(0, 1, 0, 0, 0, 0);

    // Back-to-back jobs and random traffic.
    for (int n = 0; n < 25; n++)
      run_job(int'($urandom_range(0, 7)), int'($urandom_range(0, 24)),
              int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_offset_gen.md
RAM_OFFSET_GEN -- requirements
Module: ram_offset_gen

Interface
REQ-001 SHALL have parameter FIDX_W, default 9, feature-index width.
REQ-002 SHALL have parameter LAYER_W, default 3, conv-layer index width.
REQ-003 SHALL have parameter ADDR_W, default 13, offset width.
REQ-004 SHALL have parameter NUM_LAYERS, default 6, number of valid conv layers.
REQ-005 SHALL have parameter TOP_SHIFT_TBL, default 24'h012344, 4 bits per layer (layer 0 at LSBs), top-RAM shift per layer.
REQ-006 SHALL have parameter SIDE_SHIFT, default 3, side-RAM shift (layer independent).
REQ-007 SHALL use one clock and a synchronous, active-high reset: clk_i  input  1  clock; rst_i  input  1  synchronous active-high reset.
REQ-008 SHALL have ports: start_i  input  1  job request; layer_i  input  LAYER_W  conv layer of job; fcount_i  input  FIDX_W+1  features in job.
REQ-009 SHALL have ports: base_top_i  input  ADDR_W  top-RAM base; base_side_i  input  ADDR_W  side-RAM base.
REQ-010 SHALL have ports: valid_o  output  1; ready_i  input  1; top_offset_o  output  ADDR_W; side_offset_o  output  ADDR_W; feature_index_o  output  FIDX_W; last_o  output  1.
REQ-011 SHALL have ports: busy_o  output  1  job in progress; err_o  output  1  one-cycle pulse, job rejected.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; busy_o = (state == RUN).
REQ-013 In IDLE, start_i=1 with layer_i < NUM_LAYERS and fcount_i != 0 SHALL latch layer_i, fcount_i, base_top_i and base_side_i, and enter RUN with feature index 0.
REQ-014 In IDLE, start_i=1 with layer_i >= NUM_LAYERS or fcount_i == 0 SHALL pulse err_o for one cycle and remain in IDLE.
REQ-015 start_i SHALL be ignored while in RUN; latched job parameters SHALL NOT change until the job ends.
REQ-016 valid_o SHALL be registered, asserted in the cycle after an accepted start, and stay high throughout RUN.
REQ-017 top_offset_o SHALL equal (base_top + (feature_index << TOP_SHIFT_TBL[4*layer +: 4])) mod 2^ADDR_W.
REQ-018 side_offset_o SHALL equal (base_side + (feature_index << SIDE_SHIFT)) mod 2^ADDR_W; shifted bits beyond ADDR_W SHALL be discarded silently.
REQ-019 feature_index_o SHALL present the current index; last_o SHALL be high only when index == fcount-1.
REQ-020 A beat SHALL transfer when valid_o && ready_i; on transfer, the index SHALL increment and outputs SHALL update in the next cycle.
REQ-021 When valid_o && !ready_i, all outputs SHALL hold stable (stall).
REQ-022 A transfer with last_o=1 SHALL return the FSM to IDLE with valid_o=0 and last_o=0 in the next cycle.
REQ-023 In IDLE with valid_o=0, start_i SHALL be accepted in the same cycle as the final transfer's successor cycle; back-to-back jobs SHALL leave one idle cycle.
REQ-024 fcount_i = 2^FIDX_W SHALL produce indices 0 .. 2^FIDX_W-1 with no wrap to 0 before last_o.
REQ-025 Offsets SHALL be computed combinationally from registered index/layer/base; latency from index update to offset is 0 cycles.

Reset
REQ-026 rst_i=1 at a rising edge SHALL force IDLE and clear all outputs (valid_o, last_o, busy_o, err_o, top_offset_o, side_offset_o, feature_index_o) to 0, including mid-job; start_i is ignored in that cycle.
REQ-027 After reset deassertion, the first accepted start SHALL begin at feature index 0 with no residue of the aborted job.

Verification
REQ-028 Reset, then start with layer 3, fcount 4, bases 0, ready_i=1 -> four beats, top 0,4,8,12, side 0,8,16,24, last_o on beat 4, then busy_o=0.
REQ-029 Start with layer 1, fcount 2, base_top 100, base_side 5, ready_i low for 3 cycles after first valid -> top_offset_o held at 100 for the stall, then 116; side 5 then 13.
REQ-030 Start with layer 6, then with fcount 0 -> err_o pulses once per request, valid_o stays 0, busy_o stays 0.
REQ-031 Start with layer 5, fcount 512, base_side 8000 -> 512 beats, index 511 has last_o=1, side offset wraps mod 8192 (index 24 -> 8000+192-8192 = 0).
REQ-032 Assert rst_i during beat 2 of a 10-beat job -> next cycle all outputs 0; new start with layer 0, fcount 1 -> single beat, index 0, last_o=1.
REQ-033 Pulse start_i during RUN with different layer -> ignored; offsets follow the original layer until the job ends.
